// File: rtl/ac_zone_scheduler.sv
// ---------------------------------------------------------------------------
// ac_zone_scheduler
//
// Shares one AC compressor among N_ZONES zone cooling requests. One zone
// damper is granted at a time in round-robin order. The compressor is
// protected by a minimum on time, a minimum off time (COOLDOWN) and a time
// slice. The slice forces rotation when another zone is waiting.
//
// Ports:
//   clk            rising-edge clock
//   reset          asynchronous, active-high reset
//   enable         global system enable
//   req            per-zone cooling demand, level-sensitive
//   compressor_on  compressor drive (registered)
//   grant          one-hot damper open, zero while compressor is off (registered)
//   zone_idx       index of granted zone; holds last value when idle (registered)
//   state          00 IDLE, 01 RUN, 10 COOLDOWN (registered)
// ---------------------------------------------------------------------------
module ac_zone_scheduler #(
   parameter int N_ZONES   = 4,
   parameter int MIN_ON    = 8,
   parameter int MIN_OFF   = 4,
   parameter int MAX_SLICE = 16,
   parameter int CNT_W     = 8,
   localparam int IDX_W    = (N_ZONES > 1) ? $clog2(N_ZONES) : 1
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               enable,
   input  logic [N_ZONES-1:0] req,
   output logic               compressor_on,
   output logic [N_ZONES-1:0] grant,
   output logic [IDX_W-1:0]   zone_idx,
   output logic [1:0]         state
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_RUN      = 2'b01,
      ST_COOLDOWN = 2'b10
   } state_t;

   localparam logic [CNT_W-1:0]   MIN_ON_M1    = CNT_W'(MIN_ON - 1);
   localparam logic [CNT_W-1:0]   MIN_OFF_M1   = CNT_W'(MIN_OFF - 1);
   localparam logic [CNT_W-1:0]   MAX_SLICE_M1 = CNT_W'(MAX_SLICE - 1);
   localparam logic [CNT_W-1:0]   CNT_MAX      = {CNT_W{1'b1}};
   localparam logic [N_ZONES-1:0] ONE_HOT0     = N_ZONES'(1);

   state_t               state_reg, state_next;
   logic                 compressor_on_reg, compressor_on_next;
   logic [N_ZONES-1:0]   grant_reg, grant_next;
   logic [IDX_W-1:0]     zone_idx_reg, zone_idx_next;
   logic [IDX_W-1:0]     last_reg, last_next;
   logic [CNT_W-1:0]     off_cnt_reg, off_cnt_next;
   logic [CNT_W-1:0]     run_cnt_reg, run_cnt_next;
   logic [CNT_W-1:0]     slice_cnt_reg, slice_cnt_next;

   logic [N_ZONES-1:0]   others;
   logic [IDX_W-1:0]     req_pick;
   logic [IDX_W-1:0]     oth_pick;
   logic [CNT_W-1:0]     run_cnt_inc;
   logic [CNT_W-1:0]     slice_cnt_inc;

   // Round-robin pick: first set bit above ptr, otherwise the lowest set
   // bit (the wrap-around). The descending loop leaves the lowest match.
   function automatic logic [IDX_W-1:0] rr_pick(input logic [N_ZONES-1:0] cand,
                                                input logic [IDX_W-1:0]   ptr);
      logic [IDX_W-1:0] hi_pick;
      logic [IDX_W-1:0] lo_pick;
      logic             hi_found;
      hi_pick  = '0;
      lo_pick  = '0;
      hi_found = 1'b0;
      for (int i = N_ZONES - 1; i >= 0; i--) begin
         if (cand[i]) begin
            lo_pick = IDX_W'(i);
            if (IDX_W'(i) > ptr) begin
               hi_pick  = IDX_W'(i);
               hi_found = 1'b1;
            end
         end
      end
      return hi_found ? hi_pick : lo_pick;
   endfunction

   // Requests competing with the current holder.
   assign others        = req & ~grant_reg;
   assign req_pick      = rr_pick(req, last_reg);
   assign oth_pick      = rr_pick(others, last_reg);
   assign run_cnt_inc   = (run_cnt_reg == CNT_MAX) ? run_cnt_reg : run_cnt_reg + 1'b1;
   assign slice_cnt_inc = (slice_cnt_reg == CNT_MAX) ? slice_cnt_reg : slice_cnt_reg + 1'b1;

   always_comb begin
      state_next         = state_reg;
      compressor_on_next = compressor_on_reg;
      grant_next         = grant_reg;
      zone_idx_next      = zone_idx_reg;
      last_next          = last_reg;
      off_cnt_next       = off_cnt_reg;
      run_cnt_next       = run_cnt_reg;
      slice_cnt_next     = slice_cnt_reg;

      case (state_reg)
         ST_COOLDOWN: begin
            compressor_on_next = 1'b0;
            grant_next         = '0;
            off_cnt_next       = off_cnt_reg + 1'b1;
            if (off_cnt_reg == MIN_OFF_M1) begin
               state_next = ST_IDLE;
            end
         end

         ST_IDLE: begin
            if (enable && (|req)) begin
               state_next         = ST_RUN;
               compressor_on_next = 1'b1;
               grant_next         = ONE_HOT0 << req_pick;
               zone_idx_next      = req_pick;
               last_next          = req_pick;
               run_cnt_next       = '0;
               slice_cnt_next     = '0;
            end
         end

         ST_RUN: begin
            run_cnt_next   = run_cnt_inc;
            slice_cnt_next = slice_cnt_inc;
            if (run_cnt_reg < MIN_ON_M1) begin
               // Minimum on time: nothing may stop or move the grant yet.
            end else if (!enable) begin
               state_next         = ST_COOLDOWN;
               compressor_on_next = 1'b0;
               grant_next         = '0;
               off_cnt_next       = '0;
            end else if (!req[zone_idx_reg]) begin
               if (|others) begin
                  // Handover: compressor keeps running, run_cnt continues.
                  grant_next     = ONE_HOT0 << oth_pick;
                  zone_idx_next  = oth_pick;
                  last_next      = oth_pick;
                  slice_cnt_next = '0;
               end else begin
                  state_next         = ST_COOLDOWN;
                  compressor_on_next = 1'b0;
                  grant_next         = '0;
                  off_cnt_next       = '0;
               end
            end else if ((slice_cnt_reg >= MAX_SLICE_M1) && (|others)) begin
               grant_next     = ONE_HOT0 << oth_pick;
               zone_idx_next  = oth_pick;
               last_next      = oth_pick;
               slice_cnt_next = '0;
            end
         end

         default: begin
            // Unreachable encoding: recover through a full cooldown.
            state_next         = ST_COOLDOWN;
            compressor_on_next = 1'b0;
            grant_next         = '0;
            off_cnt_next       = '0;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_reg         <= ST_COOLDOWN;
         compressor_on_reg <= 1'b0;
         grant_reg         <= '0;
         zone_idx_reg      <= '0;
         last_reg          <= IDX_W'(N_ZONES - 1);
         off_cnt_reg       <= '0;
         run_cnt_reg       <= '0;
         slice_cnt_reg     <= '0;
      end else begin
         state_reg         <= state_next;
         compressor_on_reg <= compressor_on_next;
         grant_reg         <= grant_next;
         zone_idx_reg      <= zone_idx_next;
         last_reg          <= last_next;
         off_cnt_reg       <= off_cnt_next;
         run_cnt_reg       <= run_cnt_next;
         slice_cnt_reg     <= slice_cnt_next;
      end
   end

   assign state         = state_reg;
   assign compressor_on = compressor_on_reg;
   assign grant         = grant_reg;
   assign zone_idx      = zone_idx_reg;

endmodule

// File: tb/tb_ac_zone_scheduler.sv
// ---------------------------------------------------------------------------
// tb_ac_zone_scheduler
//
// Directed bench for ac_zone_scheduler with default parameters. A vector
// table covers bring-up, minimum on time, cooldown and a round-robin pick.
// Hand-written sequences cover slice rotation, handover, enable drop during
// the minimum on time, and asynchronous reset mid-run.
// ---------------------------------------------------------------------------
module tb_ac_zone_scheduler;

   logic       clk;
   logic       reset;
   logic       enable;
   logic [3:0] req;
   logic       compressor_on;
   logic [3:0] grant;
   logic [1:0] zone_idx;
   logic [1:0] state;

   int checks;
   int failures;

   ac_zone_scheduler #(
      .N_ZONES  (4),
      .MIN_ON   (8),
      .MIN_OFF  (4),
      .MAX_SLICE(16),
      .CNT_W    (8)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .enable       (enable),
      .req          (req),
      .compressor_on(compressor_on),
      .grant        (grant),
      .zone_idx     (zone_idx),
      .state        (state)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic       en;
      logic [3:0] rq;
      logic [1:0] st;
      logic       comp;
      logic [3:0] gnt;
      logic [1:0] idx;
   } vec_t;

   vec_t vecs[19];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic check_all(input string name, input logic [1:0] st, input logic comp,
                            input logic [3:0] gnt, input logic [1:0] idx);
      check({name, " state"}, 32'(state), 32'(st));
      check({name, " comp"}, 32'(compressor_on), 32'(comp));
      check({name, " grant"}, 32'(grant), 32'(gnt));
      check({name, " idx"}, 32'(zone_idx), 32'(idx));
   endtask

   // One clock edge, then settle 1 time unit so outputs are sampled off-edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Reset held across two edges, released 1 unit after an edge.
   task automatic do_reset(input logic en, input logic [3:0] r);
      reset  = 1'b1;
      enable = en;
      req    = r;
      step();
      step();
      reset = 1'b0;
   endtask

   // Reset, then four cooldown cycles, one IDLE, and the first grant edge.
   task automatic bring_up(input logic [3:0] r);
      do_reset(1'b1, r);
      for (int i = 0; i < 5; i++) step();
      check("bringup state", 32'(state), 32'(2'b01));
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      reset    = 1'b1;
      enable   = 1'b0;
      req      = 4'b0000;

      //           en    req      state  comp  grant    idx
      vecs[0]  = '{1'b1, 4'b0001, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[1]  = '{1'b1, 4'b0001, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[2]  = '{1'b1, 4'b0001, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[3]  = '{1'b1, 4'b0001, 2'b00, 1'b0, 4'b0000, 2'd0};
      vecs[4]  = '{1'b1, 4'b0001, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[5]  = '{1'b1, 4'b0001, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[6]  = '{1'b1, 4'b0000, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[7]  = '{1'b1, 4'b0000, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[8]  = '{1'b1, 4'b0000, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[9]  = '{1'b1, 4'b0000, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[10] = '{1'b1, 4'b0000, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[11] = '{1'b1, 4'b0000, 2'b01, 1'b1, 4'b0001, 2'd0};
      vecs[12] = '{1'b1, 4'b0000, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[13] = '{1'b1, 4'b0000, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[14] = '{1'b1, 4'b0000, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[15] = '{1'b1, 4'b0000, 2'b10, 1'b0, 4'b0000, 2'd0};
      vecs[16] = '{1'b1, 4'b0000, 2'b00, 1'b0, 4'b0000, 2'd0};
      vecs[17] = '{1'b0, 4'b0100, 2'b00, 1'b0, 4'b0000, 2'd0};
      vecs[18] = '{1'b1, 4'b0100, 2'b01, 1'b1, 4'b0100, 2'd2};

      // Reset state, then bring-up / minimum on / cooldown / RR table.
      do_reset(1'b1, 4'b0001);
      check_all("reset", 2'b10, 1'b0, 4'b0000, 2'd0);
      for (int v = 0; v < 19; v++) begin
         enable = vecs[v].en;
         req    = vecs[v].rq;
         step();
         $display("vec %0d en=%b req=%b -> state=%b comp=%b grant=%b idx=%0d",
                  v, enable, req, state, compressor_on, grant, zone_idx);
         check_all($sformatf("vec%0d", v), vecs[v].st, vecs[v].comp, vecs[v].gnt, vecs[v].idx);
      end

      // Slice rotation with two zones contending: 16 cycles each.
      bring_up(4'b0101);
      for (int k = 0; k < 48; k++) begin
         check($sformatf("rot_grant k=%0d", k), 32'(grant),
               32'((((k / 16) % 2) == 0) ? 4'b0001 : 4'b0100));
         check($sformatf("rot_comp k=%0d", k), 32'(compressor_on), 32'(1'b1));
         step();
      end
      $display("seq rotation done grant=%b", grant);

      // Handover at run_cnt=10, then release with no other demand.
      bring_up(4'b0101);
      for (int k = 0; k < 10; k++) step();
      req = 4'b0100;
      step();
      check_all("handover", 2'b01, 1'b1, 4'b0100, 2'd2);
      step();
      check_all("handover_hold", 2'b01, 1'b1, 4'b0100, 2'd2);
      req = 4'b0000;
      step();
      check_all("release", 2'b10, 1'b0, 4'b0000, 2'd2);
      $display("seq handover done state=%b", state);

      // Enable drop at run_cnt=3: on time still reaches 8 cycles.
      bring_up(4'b0001);
      for (int k = 0; k < 3; k++) step();
      enable = 1'b0;
      for (int k = 4; k < 8; k++) begin
         step();
         check_all($sformatf("en_hold k=%0d", k), 2'b01, 1'b1, 4'b0001, 2'd0);
      end
      step();
      check_all("en_cool", 2'b10, 1'b0, 4'b0000, 2'd0);
      enable = 1'b1;
      for (int k = 1; k < 4; k++) begin
         step();
         check_all($sformatf("en_cool off=%0d", k), 2'b10, 1'b0, 4'b0000, 2'd0);
      end
      step();
      check_all("en_idle", 2'b00, 1'b0, 4'b0000, 2'd0);
      step();
      check_all("en_regrant", 2'b01, 1'b1, 4'b0001, 2'd0);
      $display("seq enable drop done state=%b", state);

      // Asynchronous reset between edges while running.
      bring_up(4'b0010);
      check_all("ar_run", 2'b01, 1'b1, 4'b0010, 2'd1);
      step();
      step();
      #2 reset = 1'b1;
      #1 check_all("ar_now", 2'b10, 1'b0, 4'b0000, 2'd0);
      #1 reset = 1'b0;
      for (int k = 0; k < 3; k++) begin
         step();
         check_all($sformatf("ar_cool e=%0d", k + 1), 2'b10, 1'b0, 4'b0000, 2'd0);
      end
      step();
      check_all("ar_idle", 2'b00, 1'b0, 4'b0000, 2'd0);
      step();
      check_all("ar_regrant", 2'b01, 1'b1, 4'b0010, 2'd1);
      $display("seq async reset done state=%b", state);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/ac_zone_scheduler.md
Name: ac_zone_scheduler

Overview:
- Shares one AC compressor among N_ZONES zone demand requests. Each request comes from a per-zone door/window AC control FSM output.
- Grants one zone damper at a time using round-robin order.
- Enforces compressor anti-short-cycle timing (minimum on time, minimum off time) and a time slice when several zones contend.
- Sits between the per-zone AC control FSMs and the compressor/damper drivers.

Parameters:
- N_ZONES, 4, number of requesting zones (≥2).
- MIN_ON, 8, minimum consecutive clk cycles compressor_on stays high (≥1).
- MIN_OFF, 4, minimum clk cycles spent in COOLDOWN (≥1).
- MAX_SLICE, 16, cycles a zone may hold the grant while another zone waits (≥1).
- CNT_W, 8, counter width. MIN_ON, MIN_OFF and MAX_SLICE must each be < 2^CNT_W.

Ports:
- clk  input  1  clock, rising edge.
- reset  input  1  asynchronous, active-high.
- enable  input  1  global system enable.
- req  input  N_ZONES  per-zone cooling demand, level-sensitive.
- compressor_on  output  1  compressor drive.
- grant  output  N_ZONES  one-hot damper open; all-zero when compressor is off.
- zone_idx  output  clog2(N_ZONES)  index of the granted zone; holds its last value when no zone is granted.
- state  output  2  00 IDLE, 01 RUN, 10 COOLDOWN.

Behaviour:
- Interface: reset is reset, asynchronous, active-high; clock is clk. All outputs are registered.
- Reset values:
  - state=COOLDOWN(10), compressor_on=0, grant=0, zone_idx=0.
  - Internal: off_cnt=0, run_cnt=0, slice_cnt=0, RR pointer last=N_ZONES-1, so zone 0 is first.
  - MIN_OFF is therefore enforced after reset.
- Reset mid-operation drops compressor_on and grant immediately. No minimum-on protection applies to reset.
- Round-robin selection: first set bit of the candidate set, searching from last+1 upward, wrapping to 0. On every grant change, last is set to the new index.
- COOLDOWN:
  - compressor_on=0, grant=0.
  - off_cnt is 0 in the first COOLDOWN cycle and increments each cycle.
  - When off_cnt==MIN_OFF-1, the next state is IDLE. COOLDOWN therefore lasts exactly MIN_OFF cycles.
  - req and enable are ignored.
- IDLE:
  - If enable && |req: next state RUN, grant = RR pick from req, compressor_on=1, run_cnt=0, slice_cnt=0.
  - Otherwise stay in IDLE.
- RUN:
  - run_cnt and slice_cnt increment each cycle, saturating at 2^CNT_W-1. cur denotes the granted zone.
  - Evaluate in priority order each cycle:
    1. run_cnt < MIN_ON-1: hold, regardless of req or enable.
    2. !enable: next state COOLDOWN (off_cnt=0, grant=0, compressor_on=0).
    3. !req[cur] and some other req bit set: handover to the RR pick among the others. Stay in RUN, compressor stays 1, slice_cnt=0, run_cnt continues.
    4. !req[cur] and no other req bit set: next state COOLDOWN.
    5. slice_cnt ≥ MAX_SLICE-1 and some other req bit set: rotate to the RR pick among the others (same effects as 3).
    6. Otherwise hold.
- Guarantees:
  - compressor_on is high for ≥ MIN_ON consecutive cycles.
  - compressor_on is low for ≥ MIN_OFF+1 cycles between runs (COOLDOWN plus at least one IDLE cycle).
  - grant is always one-hot or zero.
  - grant is never nonzero while compressor_on=0.
- Rotation and handover never gap the compressor. Simultaneous release and new request are handled by rule 3 as a handover, never by a cooldown.
- A request that appears in the same cycle as a COOLDOWN→IDLE transition is served on the IDLE cycle. It is granted on the following edge.
- If a requester drops req before rule 1 expires, the granted zone keeps the grant until MIN_ON is satisfied.

Test Plan (defaults):
1. Reset, then hold enable=1, req=0001.
   - Required: state=10 for 4 cycles, IDLE after edge 4; after edge 5, state=01, grant=0001, zone_idx=0, compressor_on=1.
2. Drop req=0001 after 2 RUN cycles.
   - Required: compressor_on stays high exactly 8 cycles, then state=10 with grant=0 for 4 cycles, then IDLE.
3. Hold req=0101 continuously.
   - Required: grant=0001 for 16 cycles, then 0100 for 16, then 0001, and so on; compressor_on never drops.
4. Drop req0 at run_cnt=10 while req2=1.
   - Required: grant=0100 and zone_idx=2 on the next edge, compressor_on stays 1, no COOLDOWN entered.
5. Deassert enable at run_cnt=3.
   - Required: RUN held until run_cnt=7 (8 on-cycles), then COOLDOWN.
6. Assert async reset mid-RUN, between clock edges.
   - Required: compressor_on=0, grant=0, state=10 immediately, and MIN_OFF is honoured before the next grant.
